// File: rtl/fill_pkg.sv
// Shared types for the fill-block scanline sequencer: FSM state encoding and
// the width of the read-settle / write-drain latency counter.
package fill_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MATH    = 3'd1,
    ST_READROW = 3'd2,
    ST_RWAIT   = 3'd3,
    ST_FILL    = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6
  } fill_state_e;

endpackage

// File: rtl/fill_lat_counter.sv
// Loadable down-counter with zero flag; times both the row-read settle
// (RWAIT) and the span-write drain (DRAIN) of the fill sequencer.
module fill_lat_counter
  import fill_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fill_row_sequencer.sv
// Scanline sequencer: edge-math pass, then walks rows y_min..y_max through
// read / fill / drain. Optional FILL watchdog enabled by FILL_TIMEOUT_EN.
module fill_row_sequencer
  import fill_pkg::*;
#(
  parameter int ROW_W  = 9,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2,
  parameter int TO_CYC = 1023
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             fill_en,
  input  logic [ROW_W-1:0] y_min,
  input  logic [ROW_W-1:0] y_max,
  input  logic             abort,
  input  logic             math_done,
  input  logic             fill_done,
  output logic             math_start,
  output logic             row_start,
  output logic             fill_start,
  output logic [ROW_W-1:0] row_y,
  output logic             busy,
  output logic             done,
  output logic [ROW_W:0]   rows_filled,
  output logic             timeout
);

  localparam logic [LAT_W-1:0] RD_LOAD = (RD_LAT == 0) ? '0 : LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LOAD = (WR_LAT == 0) ? '0 : LAT_W'(WR_LAT - 1);

  fill_state_e      state_q, state_d;
  logic [ROW_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic [ROW_W-1:0] row_y_q, row_y_d;
  logic [ROW_W:0]   rows_q, rows_d;
  logic             last_q, last_d;
  logic             lat_load, lat_dec, lat_zero;
  logic [LAT_W-1:0] lat_val;
  logic             adv, adv_last;

`ifdef FILL_TIMEOUT_EN
  localparam int WD_W = $clog2(TO_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d  = state_q;
    y_min_d  = y_min_q;
    y_max_d  = y_max_q;
    row_y_d  = row_y_q;
    rows_d   = rows_q;
    last_d   = last_q;
    lat_load = 1'b0;
    lat_val  = '0;
    lat_dec  = 1'b0;
    adv      = 1'b0;
    adv_last = 1'b0;
`ifdef FILL_TIMEOUT_EN
    timeout_d = timeout_q;
    wd_d      = (state_q == ST_FILL) ? wd_q + 1'b1 : '0;
`endif

    if (abort) begin
      state_d = ST_IDLE;
      row_y_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (fill_en) begin
            state_d = ST_MATH;
            y_min_d = y_min;
            y_max_d = y_max;
            row_y_d = y_min;
            rows_d  = '0;
            last_d  = 1'b0;
`ifdef FILL_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
          end
        end
        ST_MATH: begin
          if (math_done)
            state_d = (y_min_q <= y_max_q) ? ST_READROW : ST_DONE;
        end
        ST_READROW: begin
          if (RD_LAT == 0) begin
            state_d = ST_FILL;
          end else begin
            lat_load = 1'b1;
            lat_val  = RD_LOAD;
            state_d  = ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (lat_zero) state_d = ST_FILL;
          else          lat_dec = 1'b1;
        end
        ST_FILL: begin
          if (fill_done) begin
            rows_d = rows_q + 1'b1;
            last_d = (row_y_q == y_max_q);
            if (WR_LAT == 0) begin
              adv      = 1'b1;
              adv_last = last_d;
            end else begin
              lat_load = 1'b1;
              lat_val  = WR_LOAD;
              state_d  = ST_DRAIN;
            end
          end
`ifdef FILL_TIMEOUT_EN
          else if (wd_q == WD_W'(TO_CYC - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
`endif
        end
        ST_DRAIN: begin
          if (lat_zero) begin
            adv      = 1'b1;
            adv_last = last_q;
          end else begin
            lat_dec = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Row advance only ever happens below y_max_q, so row_y cannot wrap.
      if (adv) begin
        if (adv_last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READROW;
          row_y_d = row_y_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      y_min_q <= '0;
      y_max_q <= '0;
      row_y_q <= '0;
      rows_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_min_q <= y_min_d;
      y_max_q <= y_max_d;
      row_y_q <= row_y_d;
      rows_q  <= rows_d;
      last_q  <= last_d;
    end
  end

`ifdef FILL_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // No watchdog in this build; TO_CYC is referenced only to keep it meaningful.
  assign timeout = (TO_CYC < 0);
`endif

  fill_lat_counter u_lat (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (lat_load),
    .load_val (lat_val),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  assign math_start  = (state_q == ST_MATH);
  assign row_start   = (state_q == ST_READROW) || (state_q == ST_RWAIT);
  assign fill_start  = (state_q == ST_FILL);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign row_y       = row_y_q;
  assign rows_filled = rows_q;

endmodule

// File: tb/tb_fill_row_sequencer.sv
// Directed bench for fill_row_sequencer: instance A (RD_LAT=2, WR_LAT=2,
// TO_CYC=16) and instance B (RD_LAT=0, WR_LAT=0), selected by sel.
module tb_fill_row_sequencer;
  localparam int ROW_W = 9;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic fill_en = 1'b0, abort = 1'b0, math_done = 1'b0, fill_done = 1'b0;
  logic [ROW_W-1:0] y_min = '0, y_max = '0;
  bit sel = 1'b0;

  logic a_fill_en, a_abort, a_math_done, a_fill_done;
  logic b_fill_en, b_abort, b_math_done, b_fill_done;
  logic a_math_start, a_row_start, a_fill_start, a_busy, a_done, a_timeout;
  logic b_math_start, b_row_start, b_fill_start, b_busy, b_done, b_timeout;
  logic [ROW_W-1:0] a_row_y, b_row_y;
  logic [ROW_W:0]   a_rows, b_rows;

  logic o_math_start, o_row_start, o_fill_start, o_busy, o_done, o_timeout;
  logic [ROW_W-1:0] o_row_y;
  logic [ROW_W:0]   o_rows;

  assign a_fill_en = fill_en & ~sel;  assign b_fill_en = fill_en & sel;
  assign a_abort = abort & ~sel;      assign b_abort = abort & sel;
  assign a_math_done = math_done & ~sel; assign b_math_done = math_done & sel;
  assign a_fill_done = fill_done & ~sel; assign b_fill_done = fill_done & sel;

  assign o_math_start = sel ? b_math_start : a_math_start;
  assign o_row_start  = sel ? b_row_start  : a_row_start;
  assign o_fill_start = sel ? b_fill_start : a_fill_start;
  assign o_busy       = sel ? b_busy       : a_busy;
  assign o_done       = sel ? b_done       : a_done;
  assign o_timeout    = sel ? b_timeout    : a_timeout;
  assign o_row_y      = sel ? b_row_y      : a_row_y;
  assign o_rows       = sel ? b_rows       : a_rows;

  fill_row_sequencer #(.ROW_W(ROW_W), .RD_LAT(2), .WR_LAT(2), .TO_CYC(16)) dut (
    .clk(clk), .n_rst(n_rst), .fill_en(a_fill_en), .y_min(y_min), .y_max(y_max),
    .abort(a_abort), .math_done(a_math_done), .fill_done(a_fill_done),
    .math_start(a_math_start), .row_start(a_row_start), .fill_start(a_fill_start),
    .row_y(a_row_y), .busy(a_busy), .done(a_done), .rows_filled(a_rows), .timeout(a_timeout));

  fill_row_sequencer #(.ROW_W(ROW_W), .RD_LAT(0), .WR_LAT(0), .TO_CYC(16)) dut0 (
    .clk(clk), .n_rst(n_rst), .fill_en(b_fill_en), .y_min(y_min), .y_max(y_max),
    .abort(b_abort), .math_done(b_math_done), .fill_done(b_fill_done),
    .math_start(b_math_start), .row_start(b_row_start), .fill_start(b_fill_start),
    .row_y(b_row_y), .busy(b_busy), .done(b_done), .rows_filled(b_rows), .timeout(b_timeout));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Job observation record filled by run_job.
  int nrows, cycles, fill_cyc, nfd;
  int rs_len[8], ry[8];
  logic fd_rs[8], fd_done[8];
  bit job_done_seen, aborted;
  logic first_math, first_done, first_to;
  logic [ROW_W-1:0] first_rowy;
  logic [ROW_W:0] first_rows;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input bit s, input int lo, input int hi);
    sel = s; y_min = ROW_W'(lo); y_max = ROW_W'(hi); fill_en = 1'b1;
  endtask

  // Drives a job: math_done on the 3rd MATH cycle, fill_done on the 4th FILL
  // cycle (unless held off); optionally aborts in DRAIN once abort_at rows are done.
  task automatic run_job(input int max_cyc, input int abort_at, input bit hold_fill);
    int run, mcnt, fcnt;
    bit fd_prev;
    run = 0; mcnt = 0; fcnt = 0; fd_prev = 0;
    nrows = 0; cycles = -1; fill_cyc = 0; nfd = 0;
    job_done_seen = 0; aborted = 0;
    for (int i = 0; i < 8; i++) begin rs_len[i] = -1; ry[i] = -1; fd_rs[i] = 1'bx; fd_done[i] = 1'bx; end
    for (int c = 0; c < max_cyc; c++) begin
      tick();
      fill_en = 1'b0; abort = 1'b0;
      if (c == 0) begin
        first_math = o_math_start; first_done = o_done; first_to = o_timeout;
        first_rowy = o_row_y; first_rows = o_rows;
      end
      if (fd_prev) begin
        if (nfd < 8) begin fd_rs[nfd] = o_row_start; fd_done[nfd] = o_done; end
        nfd++;
      end
      if (o_row_start) begin
        if (run == 0 && nrows < 8) ry[nrows] = int'(o_row_y);
        run++;
      end else if (run != 0) begin
        if (nrows < 8) rs_len[nrows] = run;
        nrows++; run = 0;
      end
      if (o_math_start) mcnt++; else mcnt = 0;
      math_done = o_math_start && (mcnt == 3);
      if (o_fill_start) begin fcnt++; fill_cyc++; end else fcnt = 0;
      fill_done = o_fill_start && (fcnt == 4) && !hold_fill;
      fd_prev = fill_done;
      if (abort_at != 0 && int'(o_rows) == abort_at && o_busy && !o_fill_start
          && !o_row_start && !o_math_start) begin
        abort = 1'b1; math_done = 1'b0; fill_done = 1'b0; aborted = 1;
        break;
      end
      if (o_done) begin job_done_seen = 1; cycles = c; break; end
    end
    math_done = 1'b0; fill_done = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if ({a_math_start, a_row_start, a_fill_start, a_busy, a_done, a_timeout} !== 6'b0) begin n_fail++; $display("FAIL reset_a_flags got %b want 000000", {a_math_start, a_row_start, a_fill_start, a_busy, a_done, a_timeout}); end
    n_tests++; if ({b_math_start, b_row_start, b_fill_start, b_busy, b_done, b_timeout} !== 6'b0) begin n_fail++; $display("FAIL reset_b_flags got %b want 000000", {b_math_start, b_row_start, b_fill_start, b_busy, b_done, b_timeout}); end
    n_tests++; if (a_row_y !== '0 || a_rows !== '0) begin n_fail++; $display("FAIL reset_counts got row_y=%0d rows=%0d want 0/0", a_row_y, a_rows); end
    n_rst = 1'b1;
    tick();
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy got %b want 0", a_busy); end
  endtask

  task automatic test_basic();
    start(0, 5, 7);
    run_job(200, 0, 0);
    n_tests++; if (job_done_seen !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", job_done_seen); end
    n_tests++; if (first_math !== 1'b1 || first_rowy !== 9'd5) begin n_fail++; $display("FAIL basic_accept got math=%b row_y=%0d want 1/5", first_math, first_rowy); end
    n_tests++; if (nrows !== 3) begin n_fail++; $display("FAIL basic_nrows got %0d want 3", nrows); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (rs_len[i] !== 3) begin n_fail++; $display("FAIL basic_rs_len[%0d] got %0d want 3", i, rs_len[i]); end
      n_tests++; if (ry[i] !== 5 + i) begin n_fail++; $display("FAIL basic_row_y[%0d] got %0d want %0d", i, ry[i], 5 + i); end
    end
    n_tests++; if (fd_rs[0] !== 1'b0) begin n_fail++; $display("FAIL basic_drain got row_start=%b want 0", fd_rs[0]); end
    n_tests++; if (cycles !== 30) begin n_fail++; $display("FAIL basic_latency got %0d want 30", cycles); end
    n_tests++; if (o_rows !== 10'd3 || o_row_y !== 9'd7) begin n_fail++; $display("FAIL basic_final got rows=%0d row_y=%0d want 3/7", o_rows, o_row_y); end
    repeat (3) tick();
    n_tests++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_hold got done=%b busy=%b want 1/0", o_done, o_busy); end
`ifndef FILL_TIMEOUT_EN
    n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout_tied got %b want 0", o_timeout); end
`endif
  endtask

  task automatic test_back_to_back();
    start(0, 20, 21);
    run_job(200, 0, 0);
    n_tests++; if (first_math !== 1'b1 || first_done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got math=%b done=%b want 1/0", first_math, first_done); end
    n_tests++; if (first_rows !== '0 || first_rowy !== 9'd20) begin n_fail++; $display("FAIL b2b_relatch got rows=%0d row_y=%0d want 0/20", first_rows, first_rowy); end
    n_tests++; if (job_done_seen !== 1'b1 || cycles !== 21 || o_rows !== 10'd2) begin n_fail++; $display("FAIL b2b_job got done=%b cyc=%0d rows=%0d want 1/21/2", job_done_seen, cycles, o_rows); end
    n_tests++; if (ry[0] !== 20 || ry[1] !== 21) begin n_fail++; $display("FAIL b2b_rows got %0d,%0d want 20,21", ry[0], ry[1]); end
  endtask

  task automatic test_inverted();
    start(0, 10, 9);
    run_job(100, 0, 0);
    n_tests++; if (job_done_seen !== 1'b1 || cycles !== 3) begin n_fail++; $display("FAIL inv_done got done=%b cyc=%0d want 1/3", job_done_seen, cycles); end
    n_tests++; if (nrows !== 0 || o_rows !== '0) begin n_fail++; $display("FAIL inv_rows got nrows=%0d rows=%0d want 0/0", nrows, o_rows); end
  endtask

  task automatic test_boundary();
    start(0, 511, 511);
    run_job(100, 0, 0);
    n_tests++; if (job_done_seen !== 1'b1 || cycles !== 12) begin n_fail++; $display("FAIL bound_done got done=%b cyc=%0d want 1/12", job_done_seen, cycles); end
    n_tests++; if (nrows !== 1 || ry[0] !== 511) begin n_fail++; $display("FAIL bound_row got nrows=%0d row_y=%0d want 1/511", nrows, ry[0]); end
    n_tests++; if (o_row_y !== 9'd511 || o_rows !== 10'd1) begin n_fail++; $display("FAIL bound_final got row_y=%0d rows=%0d want 511/1", o_row_y, o_rows); end
  endtask

  task automatic test_zero_latency();
    start(1, 3, 4);
    run_job(100, 0, 0);
    n_tests++; if (job_done_seen !== 1'b1 || cycles !== 13) begin n_fail++; $display("FAIL zl_done got done=%b cyc=%0d want 1/13", job_done_seen, cycles); end
    n_tests++; if (rs_len[0] !== 1 || rs_len[1] !== 1) begin n_fail++; $display("FAIL zl_rs_len got %0d,%0d want 1,1", rs_len[0], rs_len[1]); end
    n_tests++; if (fd_rs[0] !== 1'b1) begin n_fail++; $display("FAIL zl_reread got row_start=%b want 1", fd_rs[0]); end
    n_tests++; if (fd_done[1] !== 1'b1) begin n_fail++; $display("FAIL zl_last got done=%b want 1", fd_done[1]); end
    n_tests++; if (ry[1] !== 4 || o_rows !== 10'd2) begin n_fail++; $display("FAIL zl_rows got row_y=%0d rows=%0d want 4/2", ry[1], o_rows); end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    bit saw;
    start(0, 0, 5);
    run_job(200, 2, 0);
    n_tests++; if (aborted !== 1'b1 || job_done_seen !== 1'b0) begin n_fail++; $display("FAIL abort_reach got aborted=%b done=%b want 1/0", aborted, job_done_seen); end
    tick();
    abort = 1'b0;
    n_tests++; if ({o_busy, o_math_start, o_row_start, o_fill_start, o_done} !== 5'b0) begin n_fail++; $display("FAIL abort_flags got %b want 00000", {o_busy, o_math_start, o_row_start, o_fill_start, o_done}); end
    n_tests++; if (o_rows !== 10'd2) begin n_fail++; $display("FAIL abort_rows got %0d want 2", o_rows); end
    saw = 0;
    repeat (3) begin tick(); saw |= o_done; end
    n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b want 0", saw); end
    start(0, 1, 2);
    run_job(200, 0, 0);
    n_tests++; if (job_done_seen !== 1'b1 || cycles !== 21 || o_rows !== 10'd2 || ry[0] !== 1) begin n_fail++; $display("FAIL abort_restart got done=%b cyc=%0d rows=%0d row0=%0d want 1/21/2/1", job_done_seen, cycles, o_rows, ry[0]); end
  endtask

  task automatic test_abort_override();
    abort = 1'b1; tick(); abort = 1'b0; tick();
    fill_en = 1'b1; abort = 1'b1; y_min = 9'd4; y_max = 9'd6;
    tick();
    fill_en = 1'b0; abort = 1'b0;
    n_tests++; if (o_busy !== 1'b0 || o_math_start !== 1'b0) begin n_fail++; $display("FAIL ovr_fill_en got busy=%b math=%b want 0/0", o_busy, o_math_start); end
    fill_done = 1'b1; math_done = 1'b1;
    tick();
    fill_done = 1'b0; math_done = 1'b0;
    n_tests++; if (o_busy !== 1'b0 || o_rows !== 10'd2) begin n_fail++; $display("FAIL ovr_stray got busy=%b rows=%0d want 0/2", o_busy, o_rows); end
  endtask

`ifdef FILL_TIMEOUT_EN
  task automatic test_timeout();
    start(0, 0, 3);
    run_job(200, 0, 1);
    n_tests++; if (job_done_seen !== 1'b1 || cycles !== 22) begin n_fail++; $display("FAIL to_done got done=%b cyc=%0d want 1/22", job_done_seen, cycles); end
    n_tests++; if (fill_cyc !== 16 || o_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag got fill_cyc=%0d timeout=%b want 16/1", fill_cyc, o_timeout); end
    n_tests++; if (o_rows !== '0) begin n_fail++; $display("FAIL to_rows got %0d want 0", o_rows); end
    start(0, 2, 2);
    run_job(100, 0, 0);
    n_tests++; if (first_to !== 1'b0 || job_done_seen !== 1'b1 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear got timeout0=%b done=%b timeout=%b want 0/1/0", first_to, job_done_seen, o_timeout); end
  endtask
`endif

  task automatic test_async_reset();
    bit hit;
    hit = 0;
    start(0, 0, 3);
    for (int c = 0; c < 50; c++) begin
      tick();
      fill_en = 1'b0;
      math_done = o_math_start;
      if (o_fill_start) begin hit = 1; break; end
    end
    math_done = 1'b0;
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL areset_reach got %b want 1", hit); end
    #2 n_rst = 1'b0;
    #1;
    n_tests++; if ({o_busy, o_fill_start, o_done} !== 3'b0 || o_row_y !== '0 || o_rows !== '0) begin n_fail++; $display("FAIL areset_clear got flags=%b row_y=%0d rows=%0d want 000/0/0", {o_busy, o_fill_start, o_done}, o_row_y, o_rows); end
    #3 n_rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_inverted();
    test_boundary();
    test_zero_latency();
    test_abort();
    test_abort_override();
`ifdef FILL_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
